// File: rtl/squeeze_pkg.sv
// -----------------------------------------------------------------------------
// squeeze_pkg
// Shared Keccak definitions used by the absorb stage, the permutation core and
// the squeeze stage.
//   LANE_W / STATE_W / NUM_LANES : Keccak-f[1600] geometry
//   RATE_*                       : rate in 64-bit lanes for the common modes
//   sq_state_e                   : squeeze FSM state encoding
//   get_lane()                   : extract lane idx (FIPS 202 order, x+5y)
// -----------------------------------------------------------------------------
package squeeze_pkg;

  localparam int LANE_W    = 64;
  localparam int STATE_W   = 1600;
  localparam int NUM_LANES = 25;

  localparam int RATE_SHA3_224 = 18;
  localparam int RATE_SHA3_256 = 17;
  localparam int RATE_SHA3_384 = 13;
  localparam int RATE_SHA3_512 = 9;
  localparam int RATE_SHAKE128 = 21;
  localparam int RATE_SHAKE256 = 17;

  typedef enum logic [1:0] {
    SQ_IDLE      = 2'd0,
    SQ_EMIT      = 2'd1,
    SQ_PERM_WAIT = 2'd2,
    SQ_DONE      = 2'd3
  } sq_state_e;

  // Constant-select mux over all 25 lanes; indices past lane 24 yield zero.
  function automatic logic [LANE_W-1:0] get_lane(input logic [STATE_W-1:0] state,
                                                 input logic [4:0]         idx);
    logic [LANE_W-1:0] lane;
    lane = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (idx == 5'(i)) begin
        lane = state[LANE_W*i +: LANE_W];
      end else begin
        lane = lane;
      end
    end
    return lane;
  endfunction

endpackage

// File: rtl/squeeze.sv
// -----------------------------------------------------------------------------
// squeeze
// Output stage of the Keccak sponge. Streams the rate lanes of the permuted
// state as 64-bit beats and requests further permutations when the requested
// output is longer than the rate (extended output).
// Ports:
//   clk, rst               clock / synchronous active-high reset
//   start, state_in        request pulse with the final permuted state
//   perm_req, state_out    permutation request and the held working state
//   perm_done, perm_state  permutation completion pulse and new state
//   out_valid/ready/data/last  lane stream to the digest consumer
//   busy, done             activity flag and end-of-request pulse
// All outputs are registered; the next-cycle values are derived from the
// next FSM state so the stream timing matches a direct Moore decode.
// -----------------------------------------------------------------------------
module squeeze
  import squeeze_pkg::*;
#(
  parameter int RATE_LANES = RATE_SHA3_256,
  parameter int OUT_LANES  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [STATE_W-1:0] state_in,
  output logic               perm_req,
  output logic [STATE_W-1:0] state_out,
  input  logic               perm_done,
  input  logic [STATE_W-1:0] perm_state,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LANE_W-1:0]  out_data,
  output logic               out_last,
  output logic               busy,
  output logic               done
);

  localparam logic [4:0] LAST_IDX = 5'(RATE_LANES - 1);
  localparam logic [7:0] OUT_CNT  = 8'(OUT_LANES);

  sq_state_e          state_r, state_nx_s;
  logic [4:0]         lane_idx_r, lane_idx_nx_s;
  logic [7:0]         remaining_r, remaining_nx_s;
  logic [STATE_W-1:0] state_out_nx_s;

  // Next-state, lane pointer, remaining-count and working-state update.
  always_comb begin
    state_nx_s     = state_r;
    lane_idx_nx_s  = lane_idx_r;
    remaining_nx_s = remaining_r;
    state_out_nx_s = state_out;
    case (state_r)
      SQ_IDLE: begin
        if (start) begin
          state_out_nx_s = state_in;
          lane_idx_nx_s  = 5'd0;
          remaining_nx_s = OUT_CNT;
          state_nx_s     = SQ_EMIT;
        end else begin
          state_nx_s = SQ_IDLE;
        end
      end
      SQ_EMIT: begin
        if (out_valid && out_ready) begin
          if (remaining_r == 8'd1) begin
            state_nx_s = SQ_DONE;
          end else if (lane_idx_r == LAST_IDX) begin
            // Rate exhausted: fresh lanes need another permutation.
            lane_idx_nx_s  = 5'd0;
            remaining_nx_s = remaining_r - 8'd1;
            state_nx_s     = SQ_PERM_WAIT;
          end else begin
            lane_idx_nx_s  = lane_idx_r + 5'd1;
            remaining_nx_s = remaining_r - 8'd1;
          end
        end else begin
          state_nx_s = SQ_EMIT;
        end
      end
      SQ_PERM_WAIT: begin
        if (perm_done) begin
          state_out_nx_s = perm_state;
          state_nx_s     = SQ_EMIT;
        end else begin
          state_nx_s = SQ_PERM_WAIT;
        end
      end
      SQ_DONE: begin
        state_nx_s = SQ_IDLE;
      end
      default: begin
        state_nx_s = SQ_IDLE;
      end
    endcase
  end

  // State, counters and registered outputs; out_data only reloads when the
  // next state emits, so it holds steady across stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= SQ_IDLE;
      lane_idx_r  <= 5'd0;
      remaining_r <= 8'd0;
      state_out   <= '0;
      out_data    <= '0;
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
      perm_req    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      lane_idx_r  <= lane_idx_nx_s;
      remaining_r <= remaining_nx_s;
      state_out   <= state_out_nx_s;
      if (state_nx_s == SQ_EMIT) begin
        out_data <= get_lane(state_out_nx_s, lane_idx_nx_s);
      end else begin
        out_data <= out_data;
      end
      out_valid <= (state_nx_s == SQ_EMIT);
      out_last  <= (state_nx_s == SQ_EMIT) && (remaining_nx_s == 8'd1);
      perm_req  <= (state_nx_s == SQ_PERM_WAIT);
      busy      <= (state_nx_s != SQ_IDLE);
      done      <= (state_nx_s == SQ_DONE);
    end
  end

endmodule

// File: tb/tb_squeeze.sv
// -----------------------------------------------------------------------------
// tb_squeeze
// Directed bench for squeeze. Two instances share clock, reset and the state
// buses: dut_a emits 4 lanes (no permutation), dut_b emits 21 lanes (one
// permutation round-trip). Expected lanes are queued when a request starts
// and popped as beats transfer.
// -----------------------------------------------------------------------------
module tb_squeeze;
  import squeeze_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst;
  logic [STATE_W-1:0] state_in, perm_state;

  logic               start_a, perm_done_a, out_ready_a;
  logic               perm_req_a, out_valid_a, out_last_a, busy_a, done_a;
  logic [STATE_W-1:0] state_out_a;
  logic [63:0]        out_data_a;

  logic               start_b, perm_done_b, out_ready_b;
  logic               perm_req_b, out_valid_b, out_last_b, busy_b, done_b;
  logic [STATE_W-1:0] state_out_b;
  logic [63:0]        out_data_b;

  squeeze #(.RATE_LANES(17), .OUT_LANES(4)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .state_in(state_in),
    .perm_req(perm_req_a), .state_out(state_out_a), .perm_done(perm_done_a),
    .perm_state(perm_state), .out_valid(out_valid_a), .out_ready(out_ready_a),
    .out_data(out_data_a), .out_last(out_last_a), .busy(busy_a), .done(done_a)
  );

  squeeze #(.RATE_LANES(17), .OUT_LANES(21)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .state_in(state_in),
    .perm_req(perm_req_b), .state_out(state_out_b), .perm_done(perm_done_b),
    .perm_state(perm_state), .out_valid(out_valid_b), .out_ready(out_ready_b),
    .out_data(out_data_b), .out_last(out_last_b), .busy(busy_b), .done(done_b)
  );

  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_q[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    chk(tag, 64'(obs), 64'(exp));
  endtask

  task automatic fill_state(output logic [STATE_W-1:0] s, input logic [63:0] base);
    for (int i = 0; i < 25; i++) s[64*i +: 64] = base | 64'(i);
  endtask

  task automatic push_lanes(input logic [63:0] base, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(base | 64'(i));
  endtask

  // Run dut_a to completion with a ready pattern; optionally poke start and
  // perm_done during EMIT (both must be ignored).
  task automatic drain_a(input logic [15:0] pat, input int pat_len, input int exp_beats,
                         input int exp_done_cyc, input bit poke);
    int          beats = 0;
    int          done_cyc = -1;
    bit          stalled = 1'b0;
    logic [63:0] held = '0;
    logic [63:0] exp;
    for (int c = 0; c < 100 && done_cyc < 0; c++) begin
      out_ready_a = (c < pat_len) ? pat[c] : 1'b1;
      if (poke && c == 1) begin
        start_a     = 1'b1;
        perm_done_a = 1'b1;
        fill_state(state_in, 64'hDEAD_0000_0000_0000);
      end
      chk1("a_no_perm_req", perm_req_a, 1'b0);
      if (out_valid_a) begin
        if (stalled) chk("a_stall_data", out_data_a, held);
        if (out_ready_a) begin
          if (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            chk("a_data", out_data_a, exp);
            chk1("a_last", out_last_a, exp_q.size() == 0);
          end else begin
            chk1("a_extra_beat", out_valid_a, 1'b0);
          end
          beats++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          held    = out_data_a;
        end
      end
      tick();
      start_a     = 1'b0;
      perm_done_a = 1'b0;
      if (done_a) done_cyc = c + 1;
    end
    chk1("a_done_seen", done_cyc >= 0, 1'b1);
    chk("a_beats", 64'(beats), 64'(exp_beats));
    if (exp_done_cyc >= 0) chk("a_done_cycle", 64'(done_cyc), 64'(exp_done_cyc));
    chk1("a_busy_in_done", busy_a, 1'b1);
    tick();
    chk1("a_done_pulse", done_a, 1'b0);
    chk1("a_busy_idle", busy_a, 1'b0);
  endtask

  // Run dut_b (21 lanes, rate 17); the model core answers perm_req on its
  // resp_delay-th cycle (1 = same cycle perm_req rises).
  task automatic drain_b(input int resp_delay);
    int          beats = 0;
    int          pr_cyc = 0;
    int          done_cyc = -1;
    bit          want_valid = 1'b0;
    bit          want_preq = 1'b0;
    logic [63:0] exp;
    for (int c = 0; c < 200 && done_cyc < 0; c++) begin
      out_ready_b = 1'b1;
      if (want_valid) begin
        chk1("b_valid_after_perm_done", out_valid_b, 1'b1);
        chk1("b_perm_req_drop", perm_req_b, 1'b0);
      end
      if (want_preq) begin
        chk1("b_perm_req_rise", perm_req_b, 1'b1);
        chk1("b_valid_low_in_wait", out_valid_b, 1'b0);
      end
      want_valid = 1'b0;
      want_preq  = 1'b0;
      if (perm_req_b) begin
        pr_cyc++;
        if (pr_cyc == resp_delay) begin
          perm_done_b = 1'b1;
          want_valid  = 1'b1;
        end
      end
      if (out_valid_b) begin
        if (exp_q.size() > 0) begin
          exp = exp_q.pop_front();
          chk("b_data", out_data_b, exp);
          chk1("b_last", out_last_b, exp_q.size() == 0);
        end else begin
          chk1("b_extra_beat", out_valid_b, 1'b0);
        end
        beats++;
        if (beats == 17) want_preq = 1'b1;
      end
      tick();
      perm_done_b = 1'b0;
      if (done_b) done_cyc = c + 1;
    end
    chk("b_beats", 64'(beats), 64'd21);
    chk("b_perm_req_cycles", 64'(pr_cyc), 64'(resp_delay));
    chk("b_done_cycle", 64'(done_cyc), 64'(21 + resp_delay));
    tick();
    chk1("b_busy_idle", busy_b, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    start_a = 1'b0; perm_done_a = 1'b0; out_ready_a = 1'b0;
    start_b = 1'b0; perm_done_b = 1'b0; out_ready_b = 1'b0;
    state_in = '0; perm_state = '0;
    repeat (3) tick();

    // Reset state
    chk1("rst_valid", out_valid_a, 1'b0);
    chk("rst_data", out_data_a, 64'd0);
    chk1("rst_last", out_last_a, 1'b0);
    chk1("rst_perm_req", perm_req_a, 1'b0);
    chk1("rst_busy", busy_a, 1'b0);
    chk1("rst_done", done_a, 1'b0);
    chk("rst_state_out", state_out_a[63:0], 64'd0);
    chk1("rst_valid_b", out_valid_b, 1'b0);
    rst = 1'b0;
    tick();

    // Basic 4-lane request, ready held high
    fill_state(state_in, 64'hA5A5_0000_0000_0000);
    push_lanes(64'hA5A5_0000_0000_0000, 4);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    chk("cap_lane0", state_out_a[63:0], 64'hA5A5_0000_0000_0000);
    chk("cap_lane24", state_out_a[STATE_W-1 -: 64], 64'hA5A5_0000_0000_0018);
    chk1("first_valid", out_valid_a, 1'b1);
    drain_a(16'hFFFF, 16, 4, 4, 1'b0);

    // Backpressure: ready 1,0,0,1,0,1,1
    fill_state(state_in, 64'h1111_0000_0000_0000);
    push_lanes(64'h1111_0000_0000_0000, 4);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    drain_a(16'h0069, 7, 4, -1, 1'b0);

    // start and perm_done during EMIT are ignored
    fill_state(state_in, 64'h2222_0000_0000_0000);
    push_lanes(64'h2222_0000_0000_0000, 4);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    drain_a(16'hFFFF, 16, 4, 4, 1'b1);

    // Reset during beat 2, then a fresh request
    fill_state(state_in, 64'h3333_0000_0000_0000);
    start_a = 1'b1;
    out_ready_a = 1'b1;
    tick();
    start_a = 1'b0;
    tick();
    tick();
    chk("mid_beat2", out_data_a, 64'h3333_0000_0000_0002);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk1("mid_rst_valid", out_valid_a, 1'b0);
    chk("mid_rst_data", out_data_a, 64'd0);
    chk1("mid_rst_last", out_last_a, 1'b0);
    chk1("mid_rst_busy", busy_a, 1'b0);
    chk1("mid_rst_done", done_a, 1'b0);
    chk("mid_rst_state_out", state_out_a[127:64], 64'd0);
    fill_state(state_in, 64'h4444_0000_0000_0000);
    exp_q.delete();
    push_lanes(64'h4444_0000_0000_0000, 4);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    chk("fresh_lane0", out_data_a, 64'h4444_0000_0000_0000);
    drain_a(16'hFFFF, 16, 4, 4, 1'b0);

    // Extended output: 17 lanes, permutation, 4 more (core answers on cycle 3)
    fill_state(state_in, 64'hAAAA_0000_0000_0000);
    fill_state(perm_state, 64'h0000_0000_0000_C000);
    push_lanes(64'hAAAA_0000_0000_0000, 17);
    push_lanes(64'h0000_0000_0000_C000, 4);
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    drain_b(3);

    // Extended output with perm_done coincident with perm_req rising
    fill_state(state_in, 64'hBBBB_0000_0000_0000);
    fill_state(perm_state, 64'h0000_0000_00D0_0000);
    push_lanes(64'hBBBB_0000_0000_0000, 17);
    push_lanes(64'h0000_0000_00D0_0000, 4);
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    drain_b(1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
